// File: rtl/fetch_unit_pkg.sv
// Shared encodings and default parameters for the instruction fetch unit.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        PC_SEQ = 2'b00,
        PC_JR  = 2'b01,
        PC_BR  = 2'b10,
        PC_J   = 2'b11
    } pc_sel_e;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC  = 2'b01,
        ST_HALT  = 2'b10
    } state_e;

    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEF_HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/fetch_unit_next_pc_calc.sv
// Combinational next-PC selection: sequential, register-indirect, branch and jump.
module next_pc_calc
    import fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic [1:0]  pc_s,
    input  logic [31:0] rs_data,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] pc_plus4_s;
    logic [31:0] br_off_s;

    assign pc_plus4_s = pc + 32'd4;
    assign br_off_s   = {{14{instr[15]}}, instr[15:0], 2'b00};

    // Target mux; all sums wrap modulo 2^32.
    always_comb begin
        next_pc = pc_plus4_s;
        case (pc_s)
            PC_SEQ:  next_pc = pc_plus4_s;
            PC_JR:   next_pc = rs_data;
            PC_BR:   next_pc = pc_plus4_s + br_off_s;
            PC_J:    next_pc = {pc_plus4_s[31:28], instr[25:0], 2'b00};
            default: next_pc = pc_plus4_s;
        endcase
    end

    assign misaligned = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// Fetch/execute sequencer: holds pc and the current instruction, requests
// instruction words, and stops on the halt encoding or a misaligned target.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] HALT_WORD = DEF_HALT_WORD
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic [1:0]  pc_s,
    input  logic [31:0] rs_data,
    input  logic        exec_done,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        halted,
    output logic        misalign_err
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        misalign_q, misalign_d;
    logic        req_q, req_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;
    logic [31:0] next_pc_s;
    logic        misaligned_s;

    next_pc_calc u_next_pc_calc (
        .pc         (pc_q),
        .instr      (instr_q),
        .pc_s       (pc_s),
        .rs_data    (rs_data),
        .next_pc    (next_pc_s),
        .misaligned (misaligned_s)
    );

    // Next-state logic; output flags are decoded from the next state so they
    // come straight from flops and read 0 while reset is held.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        misalign_d = misalign_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = (imem_rdata == HALT_WORD) ? ST_HALT : ST_EXEC;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC: begin
                if (exec_done && misaligned_s) begin
                    misalign_d = 1'b1;
                    state_d    = ST_HALT;
                end else if (exec_done) begin
                    pc_d    = next_pc_s;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_HALT;
        endcase
        req_d    = (state_d == ST_FETCH);
        valid_d  = (state_d == ST_EXEC);
        halted_d = (state_d == ST_HALT);
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0000_0000;
            misalign_q <= 1'b0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            misalign_q <= misalign_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
            halted_q   <= halted_d;
        end
    end

    assign imem_req     = req_q;
    assign imem_addr    = pc_q;
    assign pc           = pc_q;
    assign pc_plus4     = pc_q + 32'd4;
    assign instr        = instr_q;
    assign instr_valid  = valid_q;
    assign halted       = halted_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with hand-computed expectations.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [1:0]  pc_s;
    logic [31:0] rs_data;
    logic        exec_done;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        halted;
    logic        misalign_err;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .pc_s         (pc_s),
        .rs_data      (rs_data),
        .exec_done    (exec_done),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .halted       (halted),
        .misalign_err (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] word);
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack   = 1'b0;
    endtask

    task automatic exec(input logic [1:0] sel, input logic [31:0] rs);
        pc_s      = sel;
        rs_data   = rs;
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; pc_s = 2'b00;
        rs_data = 32'h0; exec_done = 1'b0;
        #2;
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_misalign", {31'b0, misalign_err}, 32'd0);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        tick();
        chk("rst_req_held", {31'b0, imem_req}, 32'd0);
        rst = 1'b0;

        // ack arrives after three idle fetch cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_req", {31'b0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, 32'h0);
        end
        chk("wait_valid", {31'b0, instr_valid}, 32'd0);
        fetch(32'h2008_0005);
        chk("f1_valid", {31'b0, instr_valid}, 32'd1);
        chk("f1_instr", instr, 32'h2008_0005);
        chk("f1_req", {31'b0, imem_req}, 32'd0);

        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        chk("exec_ack_ignored", instr, 32'h2008_0005);
        chk("exec_pc_held", pc, 32'h0);

        exec(2'b00, 32'h0);
        chk("seq_addr", imem_addr, 32'h4);
        chk("seq_req", {31'b0, imem_req}, 32'd1);

        pc_s = 2'b01; rs_data = 32'h8; exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        chk("fetch_done_ignored", imem_addr, 32'h4);
        chk("fetch_done_req", {31'b0, imem_req}, 32'd1);

        fetch(32'h0800_0004);
        exec(2'b11, 32'h0);
        chk("jump_small", imem_addr, 32'h10);

        fetch(32'h1000_FFFE);
        chk("br_pc", pc, 32'h10);
        exec(2'b10, 32'h0);
        chk("branch_back", imem_addr, 32'hC);

        fetch(32'h0000_0008);
        exec(2'b01, 32'h4000_0000);
        chk("jr_target", pc, 32'h4000_0000);

        fetch(32'h0C00_0040);
        chk("pc_plus4", pc_plus4, 32'h4000_0004);
        exec(2'b11, 32'h0);
        chk("jump_region", imem_addr, 32'h4000_0100);

        fetch(32'h0020_0008);
        exec(2'b01, 32'h0000_0123);
        chk("mis_flag", {31'b0, misalign_err}, 32'd1);
        chk("mis_halted", {31'b0, halted}, 32'd1);
        chk("mis_pc", pc, 32'h4000_0100);
        chk("mis_req", {31'b0, imem_req}, 32'd0);
        chk("mis_valid", {31'b0, instr_valid}, 32'd0);

        // asynchronous reset from HALT, between clock edges
        #3;
        rst = 1'b1;
        #1;
        chk("hrst_pc", pc, 32'h0);
        chk("hrst_halted", {31'b0, halted}, 32'd0);
        chk("hrst_misalign", {31'b0, misalign_err}, 32'd0);
        chk("hrst_req", {31'b0, imem_req}, 32'd0);
        tick();
        chk("hrst_req_held", {31'b0, imem_req}, 32'd0);
        rst = 1'b0;
        chk("hrst_req_pre_edge", {31'b0, imem_req}, 32'd0);
        tick();
        chk("hrst_req_post", {31'b0, imem_req}, 32'd1);
        chk("hrst_addr_post", imem_addr, 32'h0);

        fetch(32'h0000_0000);
        exec(2'b01, 32'hFFFF_FFFC);
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", pc_plus4, 32'h0);
        fetch(32'h0000_0000);
        exec(2'b00, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_no_flag", {31'b0, misalign_err}, 32'd0);

        fetch(32'hFFFF_FFFF);
        chk("halt_flag", {31'b0, halted}, 32'd1);
        chk("halt_req", {31'b0, imem_req}, 32'd0);
        chk("halt_pc", pc, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678; exec_done = 1'b1; pc_s = 2'b00;
        for (int i = 0; i < 3; i++) tick();
        imem_ack = 1'b0; exec_done = 1'b0;
        chk("halt_stays", {31'b0, halted}, 32'd1);
        chk("halt_pc_held", pc, 32'h0);
        chk("halt_instr_held", instr, 32'hFFFF_FFFF);
        chk("halt_req_held", {31'b0, imem_req}, 32'd0);

        // reset mid-EXEC, then a late ack is taken as the RESET_PC response
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
        fetch(32'h2008_0005);
        chk("x_valid", {31'b0, instr_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("xrst_pc", pc, 32'h0);
        chk("xrst_instr", instr, 32'h0);
        chk("xrst_valid", {31'b0, instr_valid}, 32'd0);
        chk("xrst_req", {31'b0, imem_req}, 32'd0);
        tick();
        rst = 1'b0;
        fetch(32'h1111_1110);
        chk("late_instr", instr, 32'h1111_1110);
        chk("late_valid", {31'b0, instr_valid}, 32'd1);
        chk("late_pc", pc, 32'h0);
        exec(2'b00, 32'h0);
        chk("late_next", imem_addr, 32'h4);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC value loaded on reset.
REQ-002 The block SHALL have parameter HALT_WORD, default 32'hFFFF_FFFF, giving the instruction encoding that stops fetch.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port imem_req, output, 1 bit: instruction-memory read request.
REQ-006 The block SHALL have port imem_addr, output, 32 bits: read address, equal to pc.
REQ-007 The block SHALL have port imem_ack, input, 1 bit: read data valid on imem_rdata this cycle.
REQ-008 The block SHALL have port imem_rdata, input, 32 bits: fetched instruction word.
REQ-009 The block SHALL have port instr, output, 32 bits: the latched instruction; opcode = instr[31:26] and funct = instr[5:0] feed the controller.
REQ-010 The block SHALL have port instr_valid, output, 1 bit: instr is stable and executing.
REQ-011 The block SHALL have port pc_s, input, 2 bits: next-PC select from the controller (00 seq, 01 jr, 10 branch, 11 jump).
REQ-012 The block SHALL have port rs_data, input, 32 bits: register rs value, used as the jr target.
REQ-013 The block SHALL have port exec_done, input, 1 bit: the execute stage retires instr this cycle.
REQ-014 The block SHALL have port pc, output, 32 bits: address of the current instruction.
REQ-015 The block SHALL have port pc_plus4, output, 32 bits: pc+4, used as the jal link value.
REQ-016 The block SHALL have port halted, output, 1 bit: the block is in HALT.
REQ-017 The block SHALL have port misalign_err, output, 1 bit: sticky flag for a misaligned next-PC target.

Function
REQ-018 The block SHALL implement three FSM states: FETCH, EXEC and HALT.
REQ-019 In FETCH, imem_req SHALL be 1 and instr_valid 0; the block samples imem_ack every cycle, including the first cycle of FETCH.
REQ-020 On FETCH with imem_ack=1, instr SHALL load imem_rdata and the FSM go to EXEC, so instr_valid=1 the next cycle; with imem_ack=0, the FSM stays in FETCH.
REQ-021 On FETCH with imem_ack=1 and imem_rdata==HALT_WORD, the FSM SHALL go to HALT instead of EXEC, and pc holds the address of the halt word.
REQ-022 In EXEC, imem_req SHALL be 0, instr_valid 1, and instr and pc held constant.
REQ-023 On EXEC with exec_done=1, pc SHALL load next_pc and the FSM go to FETCH, so imem_req=1 with the new address the next cycle.
REQ-024 next_pc for pc_s=00 SHALL be pc_plus4.
REQ-025 next_pc for pc_s=01 SHALL be rs_data.
REQ-026 next_pc for pc_s=10 SHALL be pc_plus4 + (sign-extended instr[15:0] << 2).
REQ-027 next_pc for pc_s=11 SHALL be {pc_plus4[31:28], instr[25:0], 2'b00}.
REQ-028 All PC arithmetic SHALL be 32-bit modulo 2^32, so pc=32'hFFFF_FFFC gives pc_plus4=0 without any flag.
REQ-029 If exec_done=1 and next_pc[1:0]!=0, pc SHALL NOT change, misalign_err SHALL set and the FSM go to HALT.
REQ-030 HALT SHALL be exited only by rst; in HALT, imem_req=0, instr_valid=0 and halted=1.
REQ-031 imem_ack outside FETCH and exec_done outside EXEC SHALL be ignored.
REQ-032 pc_plus4 SHALL always be combinationally pc+4.
REQ-033 Minimum instruction period SHALL be 2 cycles: ack in cycle n, and exec_done in cycle n+1.

Reset
REQ-034 Asserting rst SHALL immediately set pc=RESET_PC, instr=0, FSM=FETCH, misalign_err=0, instr_valid=0 and halted=0.
REQ-035 While rst=1, imem_req SHALL be 0; after rst deasserts, it SHALL be 1 from the first clock edge onward.
REQ-036 rst asserted mid-fetch or mid-exec SHALL abandon the transaction; a late imem_ack after reset SHALL be treated as the response for RESET_PC.

Structure
REQ-037 A shared package SHALL hold the pc_s encodings (PC_SEQ=00, PC_JR=01, PC_BR=10, PC_J=11), the FSM state encoding and the default RESET_PC and HALT_WORD values.
REQ-038 next-PC computation SHALL be a combinational sub-module next_pc_calc with inputs pc, instr, pc_s, rs_data and outputs next_pc and misaligned.
REQ-039 The FSM, pc register, instr register and sticky flag SHALL reside in fetch_unit.

Verification
REQ-040 Reset then ack delayed 3 cycles with rdata=32'h2008_0005 -> imem_addr=0 for 4 cycles; instr_valid=1 next cycle; exec_done with pc_s=00 -> imem_addr=4.
REQ-041 pc=32'h0000_0010, instr=32'h1000_FFFE, pc_s=10, exec_done -> next imem_addr=32'h0000_000C.
REQ-042 pc=32'h4000_0000, instr=32'h0C00_0040, pc_s=11 -> imem_addr=32'h4000_0100; with pc_s=01 and rs_data=32'h0000_0123 -> misalign_err=1, halted=1, pc unchanged.
REQ-043 pc=32'hFFFF_FFFC, pc_s=00 -> pc_plus4=0 and next imem_addr=0; HALT_WORD fetched -> halted=1, imem_req=0, exec_done and imem_ack ignored.
REQ-044 rst pulsed mid-EXEC and in HALT -> asynchronous return to pc=RESET_PC, imem_req=0 during reset, and imem_req=1 on the first edge after release.
